demux1to3_buf: RTL and testbench

- Registered 1-to-3 demultiplexer, the inverse of the datapath 3-to-1 select muxes.
- Routes one 32-bit source word (ALU/memory result) to one of three consumers (register-file writeback, PC-update logic, data-memory write port), chosen by a 2-bit select.
- Each destination has a one-entry holding register with a valid/ready handshake, so a stalled consumer back-pressures the source and never loses data.

---
 rtl/demux1to3_buf.sv | 180 ++++++++++++++++++
 tb/tb_demux1to3_buf.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux1to3_buf.sv
// Purpose : registered 1-to-3 demux; routes one source word to one of three
//           consumers, each behind a one-entry valid/ready holding register.
// Latency : 1 cycle from accept (in_valid && in_ready) to vld_k.
// Backpr. : in_ready drops only when the selected channel is full and its
//           consumer is not taking the word this cycle; s=3 is always accepted.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   d, s, in_valid        source word, destination select (3 = illegal), valid
//   in_ready              combinational accept for the presented select
//   out0..2, vld0..2      channel holding registers and their valid flags
//   rdy0..2               consumer k takes out_k this cycle
//   err_sel               one-cycle pulse after an illegal select is accepted
//   cnt0..2               delivered-word counters (zero unless the optional
//                         counter build is selected)
//
// Optional feature macro: DEMUX1TO3_CNT_EN builds per-channel delivered-word
// counters that wrap modulo 2^CNT_W. Without it cnt0..2 are constant zero.

module demux1to3_buf #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       s,
  input  logic             in_valid,
  output logic             in_ready,

  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic             vld0,
  output logic             vld1,
  output logic             vld2,
  input  logic             rdy0,
  input  logic             rdy1,
  input  logic             rdy2,

  output logic             err_sel,

  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] out0_q, out0_d;
  logic [WIDTH-1:0] out1_q, out1_d;
  logic [WIDTH-1:0] out2_q, out2_d;
  logic [2:0]       vld_q,  vld_d;
  logic             err_q,  err_d;

  // --------------------------------------------------------------------------
  // Handshake decode
  // --------------------------------------------------------------------------
  logic [2:0] rdy_vec;   // consumer ready, bit k = channel k
  logic [2:0] drain;     // channel k delivers its word at the next edge
  logic [2:0] wr;        // channel k is loaded at the next edge
  logic       accept;
  logic       illegal_acc;

  assign rdy_vec = {rdy2, rdy1, rdy0};

  // rdy_k only means something while the channel actually holds a word.
  assign drain = vld_q & rdy_vec;

  // A full channel that is draining this cycle still has room, so the
  // ready path looks at the drain, not just the valid flag.
  always_comb begin
    in_ready = 1'b1;
    case (s)
      2'd0:    in_ready = !vld_q[0] || rdy_vec[0];
      2'd1:    in_ready = !vld_q[1] || rdy_vec[1];
      2'd2:    in_ready = !vld_q[2] || rdy_vec[2];
      default: in_ready = 1'b1;  // illegal select: swallowed, never stalls
    endcase
  end

  assign accept      = in_valid && in_ready;
  assign illegal_acc = accept && (s == 2'd3);

  assign wr = {accept && (s == 2'd2),
               accept && (s == 2'd1),
               accept && (s == 2'd0)};

  // --------------------------------------------------------------------------
  // Next state
  // --------------------------------------------------------------------------
  // A write takes priority over a drain: when both hit the same channel the
  // old word leaves this edge and the new one lands, so vld stays high.
  always_comb begin
    vld_d = vld_q;
    for (int k = 0; k < 3; k++) begin
      if (wr[k]) begin
        vld_d[k] = 1'b1;
      end else if (drain[k]) begin
        vld_d[k] = 1'b0;
      end
    end
  end

  // Data registers only move on a write, so out_k is stable while vld_k=1
  // and keeps its last word after it has been delivered.
  always_comb begin
    out0_d = wr[0] ? d : out0_q;
    out1_d = wr[1] ? d : out1_q;
    out2_d = wr[2] ? d : out2_q;
  end

  assign err_d = illegal_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0_q <= '0;
      out1_q <= '0;
      out2_q <= '0;
      vld_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      out0_q <= out0_d;
      out1_q <= out1_d;
      out2_q <= out2_d;
      vld_q  <= vld_d;
      err_q  <= err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign out0    = out0_q;
  assign out1    = out1_q;
  assign out2    = out2_q;
  assign vld0    = vld_q[0];
  assign vld1    = vld_q[1];
  assign vld2    = vld_q[2];
  assign err_sel = err_q;

  // --------------------------------------------------------------------------
  // Delivered-word counters
  // --------------------------------------------------------------------------
`ifdef DEMUX1TO3_CNT_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic [CNT_W-1:0] cnt2_q, cnt2_d;

  // Natural binary overflow gives the modulo-2^CNT_W wrap.
  always_comb begin
    cnt0_d = drain[0] ? cnt0_q + CNT_W'(1) : cnt0_q;
    cnt1_d = drain[1] ? cnt1_q + CNT_W'(1) : cnt1_q;
    cnt2_d = drain[2] ? cnt2_q + CNT_W'(1) : cnt2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
      cnt2_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
      cnt2_q <= cnt2_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
  assign cnt2 = cnt2_q;
`else
  assign cnt0 = '0;
  assign cnt1 = '0;
  assign cnt2 = '0;
`endif

endmodule

// File: tb/tb_demux1to3_buf.sv
// Bench for demux1to3_buf: directed stimulus, expected words queued per
// channel at accept time, a negedge monitor pops and compares on delivery.
module tb_demux1to3_buf;

  localparam int W  = 32;
  localparam int CW = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic [W-1:0]  d     = '0;
  logic [1:0]    s     = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  out0, out1, out2;
  logic          vld0, vld1, vld2;
  logic          rdy0 = 1'b0, rdy1 = 1'b0, rdy2 = 1'b0;
  logic          err_sel;
  logic [CW-1:0] cnt0, cnt1, cnt2;

  demux1to3_buf #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .d        (d),
    .s        (s),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out0     (out0),
    .out1     (out1),
    .out2     (out2),
    .vld0     (vld0),
    .vld1     (vld1),
    .vld2     (vld2),
    .rdy0     (rdy0),
    .rdy1     (rdy1),
    .rdy2     (rdy2),
    .err_sel  (err_sel),
    .cnt0     (cnt0),
    .cnt1     (cnt1),
    .cnt2     (cnt2)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard queues
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic [W-1:0] q2[$];
  int           errq[$];   // cycle numbers on which err_sel must be high

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic deliver(input string name, input logic [W-1:0] act, input int sz, output logic [W-1:0] front);
    front = '0;
    if (sz == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: delivered 0x%0h with nothing expected (t=%0t)", name, act, $time);
    end
  endtask

  // Monitor: a word is delivered on the edge following a negedge where
  // vld_k && rdy_k, and out_k is stable across that window.
  always @(negedge clk) begin
    logic [W-1:0] tmp;
    logic         exp_err;
    if (rst_n) begin
      if (vld0 && rdy0) begin
        if (q0.size() == 0) deliver("deliver0", out0, 0, tmp);
        else check("deliver0", out0, q0.pop_front());
      end
      if (vld1 && rdy1) begin
        if (q1.size() == 0) deliver("deliver1", out1, 0, tmp);
        else check("deliver1", out1, q1.pop_front());
      end
      if (vld2 && rdy2) begin
        if (q2.size() == 0) deliver("deliver2", out2, 0, tmp);
        else check("deliver2", out2, q2.pop_front());
      end
      exp_err = (errq.size() > 0) && (errq[0] == cyc);
      if (exp_err) void'(errq.pop_front());
      check("err_sel", err_sel, exp_err);
    end
  end

  // Present a word starting just after a posedge; wait (bounded) for
  // in_ready, queue the expected result, return just after the accept edge.
  task automatic send(input int ch, input logic [W-1:0] data, output int waits);
    logic done;
    waits    = 0;
    done     = 1'b0;
    d        = data;
    s        = 2'(ch);
    in_valid = 1'b1;
    while (!done && waits < 50) begin
      @(negedge clk);
      if (in_ready) begin
        case (ch)
          0:       q0.push_back(data);
          1:       q1.push_back(data);
          2:       q2.push_back(data);
          default: errq.push_back(cyc + 1);
        endcase
        done = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: ch %0d never accepted, got in_ready=0 required 1", ch);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out0"}, out0, 0);
    check({tag, "_out1"}, out1, 0);
    check({tag, "_out2"}, out2, 0);
    check({tag, "_vld"},  {vld2, vld1, vld0}, 0);
    check({tag, "_err"},  err_sel, 0);
    check({tag, "_cnt"},  {cnt2, cnt1, cnt0}, 0);
  endtask

  // Assert reset between edges, check outputs clear immediately, release
  // mid-cycle and resume just after a posedge.
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    q0.delete(); q1.delete(); q2.delete(); errq.delete();
    #1;
    check_all_zero(tag);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    logic [CW-1:0] exp_cnt2;

    // ---------------- reset state
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset");
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // ---------------- basic route
    rdy1 = 1'b1;
    send(1, 32'hDEADBEEF, w);
    @(negedge clk);
    check("basic_vld1", vld1, 1);
    check("basic_out1", out1, 32'hDEADBEEF);
    check("basic_vld0_vld2", {vld2, vld0}, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("basic_vld1_clear", vld1, 0);
    check("basic_out1_hold", out1, 32'hDEADBEEF);
    @(posedge clk); #1;
    rdy1 = 1'b0;

    // ---------------- back-pressure
    rdy0 = 1'b0;
    send(0, 32'h11111111, w);
    d = 32'h22222222; s = 2'd0; in_valid = 1'b1;
    @(negedge clk);
    check("bp_stall_rdy", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_stall_rdy2", in_ready, 0);
    check("bp_out0_held", out0, 32'h11111111);
    check("bp_vld0_full", vld0, 1);
    @(posedge clk); #1;
    rdy0 = 1'b1;
    @(negedge clk);
    check("bp_release_rdy", in_ready, 1);
    q0.push_back(32'h22222222);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rdy0 = 1'b0;
    @(negedge clk);
    check("bp_vld0_no_bubble", vld0, 1);
    check("bp_out0_new", out0, 32'h22222222);
    @(posedge clk); #1;
    rdy0 = 1'b1;
    @(posedge clk); #1;
    rdy0 = 1'b0;
    @(negedge clk);
    check("bp_vld0_drained", vld0, 0);
    @(posedge clk); #1;

    // ---------------- independent channels
    rdy2 = 1'b0;
    send(2, 32'hAAAA0002, w);
    send(0, 32'h00000005, w);
    check("ind_ch0_no_wait", w, 0);
    @(negedge clk);
    check("ind_vld0", vld0, 1);
    check("ind_vld2", vld2, 1);
    check("ind_out2", out2, 32'hAAAA0002);
    check("ind_out0", out0, 32'h00000005);
    @(posedge clk); #1;
    rdy0 = 1'b1; rdy2 = 1'b1;
    @(posedge clk); #1;
    rdy0 = 1'b0; rdy2 = 1'b0;
    @(negedge clk);
    check("ind_drained", {vld2, vld0}, 0);
    @(posedge clk); #1;

    // ---------------- illegal select, back to back
    send(3, 32'hFFFFFFFF, w);
    check("ill_no_wait_a", w, 0);
    send(3, 32'hFFFFFFFF, w);
    check("ill_no_wait_b", w, 0);
    @(negedge clk);
    check("ill_err_hi", err_sel, 1);
    check("ill_vld", {vld2, vld1, vld0}, 0);
    check("ill_out0", out0, 32'h00000005);
    check("ill_out1", out1, 32'hDEADBEEF);
    check("ill_out2", out2, 32'hAAAA0002);
    @(posedge clk); #1;
    @(negedge clk);
    check("ill_err_lo", err_sel, 0);
    @(posedge clk); #1;

    // ---------------- async reset mid-operation
    send(0, 32'h12345678, w);
    send(1, 32'h9ABCDEF0, w);
    check("pre_rst_vld", {vld1, vld0}, 2'b11);
    do_reset("midrst");
    rdy1 = 1'b1;
    send(1, 32'hDEADBEEF, w);
    @(negedge clk);
    check("post_rst_vld1", vld1, 1);
    check("post_rst_out1", out1, 32'hDEADBEEF);
    check("post_rst_vld0_vld2", {vld2, vld0}, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_vld1_clear", vld1, 0);
    @(posedge clk); #1;
    rdy1 = 1'b0;

    // ---------------- counters: 17 deliveries on ch2
    do_reset("cntrst");
    rdy2 = 1'b1;
    for (int i = 0; i < 17; i++) begin
      send(2, 32'h0000_0100 + 32'(i), w);
    end
    repeat (3) @(negedge clk);
`ifdef DEMUX1TO3_CNT_EN
    exp_cnt2 = 4'd1;
`else
    exp_cnt2 = 4'd0;
`endif
    check("cnt2_wrap", cnt2, exp_cnt2);
    check("cnt0_idle", cnt0, 0);
    check("cnt1_idle", cnt1, 0);
    @(posedge clk); #1;
    rdy2 = 1'b0;
    @(posedge clk); #1;

    // ---------------- everything queued was delivered
    check("q0_empty", q0.size(), 0);
    check("q1_empty", q1.size(), 0);
    check("q2_empty", q2.size(), 0);
    check("errq_empty", errq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

endmodule
